cpu_sequencer: RTL and testbench

//  Moore-FSM control sequencer for the basic 8-bit sysbus processor. Upstream of the RAM, PC, IR, ACC and ALU.

---
 rtl/cpu_sequencer_if.sv | 36 +++
 rtl/cpu_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - control bundle between the sequencer and the sysbus datapath
interface cpu_sequencer_if #(
    parameter int OP_W = 3
);
    logic [OP_W-1:0] op;
    logic            z_flag;
    logic            PC_bus;
    logic            load_PC;
    logic            INC_PC;
    logic            load_IR;
    logic            Addr_bus;
    logic            ACC_bus;
    logic            load_ACC;
    logic            ALU_ACC;
    logic            ALU_add;
    logic            ALU_sub;
    logic            load_MAR;
    logic            load_MDR;
    logic            MDR_bus;
    logic            CS;
    logic            R_NW;

    // Sequencer side: receives opcode and zero flag, drives every strobe.
    modport master (
        input  op, z_flag,
        output PC_bus, load_PC, INC_PC, load_IR, Addr_bus, ACC_bus, load_ACC,
               ALU_ACC, ALU_add, ALU_sub, load_MAR, load_MDR, MDR_bus, CS, R_NW
    );

    // Datapath side: supplies opcode and zero flag, obeys the strobes.
    modport slave (
        output op, z_flag,
        input  PC_bus, load_PC, INC_PC, load_IR, Addr_bus, ACC_bus, load_ACC,
               ALU_ACC, ALU_add, ALU_sub, load_MAR, load_MDR, MDR_bus, CS, R_NW
    );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - Moore fetch/decode/execute sequencer for the 8-bit sysbus CPU (optional HALT state: HALT_SEQ_EN)
module cpu_sequencer #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clock,
    input  logic             n_reset,
    cpu_sequencer_if.master  ctl,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    // The opcode field must fit in a bus word.
    if (WORD_W < OP_W) begin : g_width_check
        $error("cpu_sequencer: OP_W wider than WORD_W");
    end

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(5);
`ifdef HALT_SEQ_EN
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);
`endif

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH0 = 4'd1,
        S_FETCH1 = 4'd2,
        S_FETCH2 = 4'd3,
        S_DECODE = 4'd4,
        S_MREAD  = 4'd5,
        S_EXEC   = 4'd6,
        S_WDATA  = 4'd7,
        S_MWRITE = 4'd8
`ifdef HALT_SEQ_EN
        ,
        S_HALT   = 4'd9
`endif
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [OP_W-1:0] op_q;
    logic            retire;

    // State register; asynchronous reset abandons any instruction in flight.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Opcode captured in decode so later states ignore IR changes; retired count.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            op_q      <= '0;
            instr_cnt <= '0;
        end else begin
            if (state == S_DECODE) begin
                op_q <= ctl.op;
            end
            if (retire) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and retire decode.
    always_comb begin
        state_next = S_FETCH0;
        retire     = 1'b0;
        case (state)
            S_RESET:  state_next = S_FETCH0;
            S_FETCH0: state_next = S_FETCH1;
            S_FETCH1: state_next = S_FETCH2;
            S_FETCH2: state_next = S_DECODE;
            S_DECODE: begin
                case (ctl.op)
                    OP_LOAD, OP_ADD, OP_SUB: state_next = S_MREAD;
                    OP_STORE:                state_next = S_WDATA;
`ifdef HALT_SEQ_EN
                    OP_HALT: begin
                        state_next = S_HALT;
                        retire     = 1'b1;
                    end
`endif
                    default: begin
                        state_next = S_FETCH0;
                        retire     = 1'b1;
                    end
                endcase
            end
            S_MREAD:  state_next = S_EXEC;
            S_EXEC: begin
                state_next = S_FETCH0;
                retire     = 1'b1;
            end
            S_WDATA:  state_next = S_MWRITE;
            S_MWRITE: begin
                state_next = S_FETCH0;
                retire     = 1'b1;
            end
`ifdef HALT_SEQ_EN
            S_HALT:   state_next = S_HALT;
`endif
            default:  state_next = S_FETCH0;
        endcase
    end

    // Strobe decode from the registered state; R_NW idles high (read).
    always_comb begin
        ctl.PC_bus   = 1'b0;
        ctl.load_PC  = 1'b0;
        ctl.INC_PC   = 1'b0;
        ctl.load_IR  = 1'b0;
        ctl.Addr_bus = 1'b0;
        ctl.ACC_bus  = 1'b0;
        ctl.load_ACC = 1'b0;
        ctl.ALU_ACC  = 1'b0;
        ctl.ALU_add  = 1'b0;
        ctl.ALU_sub  = 1'b0;
        ctl.load_MAR = 1'b0;
        ctl.load_MDR = 1'b0;
        ctl.MDR_bus  = 1'b0;
        ctl.CS       = 1'b0;
        ctl.R_NW     = 1'b1;
        halted       = 1'b0;
        case (state)
            S_FETCH0: begin
                ctl.PC_bus   = 1'b1;
                ctl.load_MAR = 1'b1;
                ctl.INC_PC   = 1'b1;
                ctl.load_PC  = 1'b1;
            end
            S_FETCH1: ctl.CS = 1'b1;
            S_FETCH2: begin
                ctl.MDR_bus = 1'b1;
                ctl.load_IR = 1'b1;
            end
            S_DECODE: begin
                case (ctl.op)
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB: begin
                        ctl.Addr_bus = 1'b1;
                        ctl.load_MAR = 1'b1;
                    end
                    OP_BNE: begin
                        ctl.Addr_bus = !ctl.z_flag;
                        ctl.load_PC  = !ctl.z_flag;
                    end
                    OP_JMP: begin
                        ctl.Addr_bus = 1'b1;
                        ctl.load_PC  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MREAD:  ctl.CS = 1'b1;
            S_EXEC: begin
                ctl.MDR_bus  = 1'b1;
                ctl.load_ACC = 1'b1;
                ctl.ALU_ACC  = 1'b1;
                ctl.ALU_add  = (op_q == OP_ADD);
                ctl.ALU_sub  = (op_q == OP_SUB);
            end
            S_WDATA: begin
                ctl.ACC_bus  = 1'b1;
                ctl.load_MDR = 1'b1;
            end
            S_MWRITE: begin
                ctl.CS   = 1'b1;
                ctl.R_NW = 1'b0;
            end
`ifdef HALT_SEQ_EN
            S_HALT:   halted = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer with a small sysbus datapath model
module tb_cpu_sequencer;

    localparam logic [15:0] B_HALT   = 16'h8000;
    localparam logic [15:0] B_PCBUS  = 16'h4000;
    localparam logic [15:0] B_LDPC   = 16'h2000;
    localparam logic [15:0] B_INC    = 16'h1000;
    localparam logic [15:0] B_LDIR   = 16'h0800;
    localparam logic [15:0] B_ADDR   = 16'h0400;
    localparam logic [15:0] B_ACCBUS = 16'h0200;
    localparam logic [15:0] B_LDACC  = 16'h0100;
    localparam logic [15:0] B_ALUACC = 16'h0080;
    localparam logic [15:0] B_ADD    = 16'h0040;
    localparam logic [15:0] B_SUB    = 16'h0020;
    localparam logic [15:0] B_LDMAR  = 16'h0010;
    localparam logic [15:0] B_LDMDR  = 16'h0008;
    localparam logic [15:0] B_MDRBUS = 16'h0004;
    localparam logic [15:0] B_CS     = 16'h0002;
    localparam logic [15:0] B_RNW    = 16'h0001;

    logic        clock = 1'b0;
    logic        n_reset = 1'b0;
    logic        halted;
    logic [15:0] instr_cnt;
    logic [15:0] strobes;

    logic [4:0]  pc;
    logic [4:0]  mar;
    logic [7:0]  ir;
    logic [7:0]  mdr;
    logic [7:0]  acc;
    logic [7:0]  sysbus;
    logic [7:0]  ram [32];
    logic [4:0]  reset_pc = 5'd0;
    logic        prog_loaded = 1'b0;

    logic [15:0] sb[$];
    logic [15:0] exp_v;
    int          checks = 0;
    int          errors = 0;

    cpu_sequencer_if #(.OP_W(3)) ctl();

    cpu_sequencer #(.WORD_W(8), .OP_W(3), .CNT_W(16)) dut (
        .clock     (clock),
        .n_reset   (n_reset),
        .ctl       (ctl.master),
        .halted    (halted),
        .instr_cnt (instr_cnt)
    );

    always #5 clock = ~clock;

    assign ctl.op     = ir[7:5];
    assign ctl.z_flag = (acc == 8'h00);

    assign strobes = {halted, ctl.PC_bus, ctl.load_PC, ctl.INC_PC, ctl.load_IR,
                      ctl.Addr_bus, ctl.ACC_bus, ctl.load_ACC, ctl.ALU_ACC,
                      ctl.ALU_add, ctl.ALU_sub, ctl.load_MAR, ctl.load_MDR,
                      ctl.MDR_bus, ctl.CS, ctl.R_NW};

    always_comb begin
        sysbus = 8'h00;
        if (ctl.PC_bus)   sysbus = {3'b000, pc};
        if (ctl.Addr_bus) sysbus = {3'b000, ir[4:0]};
        if (ctl.ACC_bus)  sysbus = acc;
        if (ctl.MDR_bus)  sysbus = mdr;
    end

    // Datapath model: PC, MAR, IR, MDR, ACC and RAM obeying the strobes.
    always @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            pc <= reset_pc;
            if (!prog_loaded) begin
                for (int i = 0; i < 32; i++) ram[i] <= 8'h00;
                ram[0]  <= 8'h18;  ram[1]  <= 8'h59;  ram[2]  <= 8'h1B;
                ram[3]  <= 8'h3A;  ram[4]  <= 8'h94;  ram[5]  <= 8'hC0;
                ram[6]  <= 8'h3C;  ram[9]  <= 8'hE0;  ram[10] <= 8'h18;
                ram[20] <= 8'h7B;  ram[21] <= 8'h88;  ram[22] <= 8'hA5;
                ram[24] <= 8'h03;  ram[25] <= 8'h04;  ram[27] <= 8'h5A;
                ram[28] <= 8'h11;
                acc <= 8'h00; ir <= 8'h00; mar <= 5'd0; mdr <= 8'h00;
                prog_loaded <= 1'b1;
            end
        end else begin
            if (ctl.load_MAR) mar <= sysbus[4:0];
            if (ctl.load_PC)  pc  <= ctl.INC_PC ? pc + 5'd1 : sysbus[4:0];
            if (ctl.load_IR)  ir  <= sysbus;
            if (ctl.CS && ctl.R_NW)  mdr <= ram[mar];
            else if (ctl.load_MDR)   mdr <= sysbus;
            if (ctl.CS && !ctl.R_NW) ram[mar] <= mdr;
            if (ctl.load_ACC)
                acc <= ctl.ALU_add ? acc + sysbus : (ctl.ALU_sub ? acc - sysbus : sysbus);
        end
    end

    function automatic void push_instr(input logic [2:0] op, input logic z);
        sb.push_back(B_PCBUS | B_LDMAR | B_INC | B_LDPC | B_RNW);
        sb.push_back(B_CS | B_RNW);
        sb.push_back(B_MDRBUS | B_LDIR | B_RNW);
        case (op)
            3'd0, 3'd2, 3'd3: begin
                sb.push_back(B_ADDR | B_LDMAR | B_RNW);
                sb.push_back(B_CS | B_RNW);
                sb.push_back(B_MDRBUS | B_LDACC | B_ALUACC | B_RNW |
                             ((op == 3'd2) ? B_ADD : 16'h0) | ((op == 3'd3) ? B_SUB : 16'h0));
            end
            3'd1: begin
                sb.push_back(B_ADDR | B_LDMAR | B_RNW);
                sb.push_back(B_ACCBUS | B_LDMDR | B_RNW);
                sb.push_back(B_CS);
            end
            3'd4:    sb.push_back(z ? B_RNW : (B_ADDR | B_LDPC | B_RNW));
            3'd5:    sb.push_back(B_ADDR | B_LDPC | B_RNW);
            default: sb.push_back(B_RNW);
        endcase
    endfunction

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (strobes !== B_RNW) begin errors++; $display("FAIL reset_strobes: got %h expected %h", strobes, B_RNW); end
        checks++;
        if (instr_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", instr_cnt); end
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        @(negedge clock);
        n_reset = 1'b1;
        #1;
        checks++;
        if (strobes !== B_RNW) begin errors++; $display("FAIL s_reset_cycle: got %h expected %h", strobes, B_RNW); end
    endtask

    task automatic test_load_add();
        push_instr(3'd0, 1'b0);
        push_instr(3'd2, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL load_add_sb: queue empty at cycle %0d", i); end
            else begin
                exp_v = sb.pop_front();
                if (strobes !== exp_v) begin errors++; $display("FAIL load_add cycle %0d: got %h expected %h", i, strobes, exp_v); end
            end
        end
        @(posedge clock); #1;
        checks++;
        if (acc !== 8'h07) begin errors++; $display("FAIL load_add_acc: got %h expected 07", acc); end
        checks++;
        if (instr_cnt !== 16'd2) begin errors++; $display("FAIL load_add_cnt: got %0d expected 2", instr_cnt); end
    endtask

    task automatic test_store();
        push_instr(3'd0, 1'b0);
        push_instr(3'd1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL store_sb: queue empty at cycle %0d", i); end
            else begin
                exp_v = sb.pop_front();
                if (strobes !== exp_v) begin errors++; $display("FAIL store cycle %0d: got %h expected %h", i, strobes, exp_v); end
            end
        end
        @(posedge clock); #1;
        checks++;
        if (ram[26] !== 8'h5A) begin errors++; $display("FAIL store_ram: got %h expected 5a", ram[26]); end
        checks++;
        if (instr_cnt !== 16'd4) begin errors++; $display("FAIL store_cnt: got %0d expected 4", instr_cnt); end
    endtask

    task automatic test_bne_jmp();
        logic [2:0] t_op  [5] = '{3'd4, 3'd3, 3'd4, 3'd5, 3'd6};
        logic       t_z   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int         t_cyc [5] = '{4, 6, 4, 4, 4};
        logic [4:0] t_pc  [5] = '{5'd20, 5'd21, 5'd22, 5'd5, 5'd6};
        logic [7:0] t_acc [5] = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int k = 0; k < 5; k++) begin
            push_instr(t_op[k], t_z[k]);
            for (int i = 0; i < t_cyc[k]; i++) begin
                @(negedge clock);
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL flow_sb: queue empty instr %0d cycle %0d", k, i); end
                else begin
                    exp_v = sb.pop_front();
                    if (strobes !== exp_v) begin errors++; $display("FAIL flow instr %0d cycle %0d: got %h expected %h", k, i, strobes, exp_v); end
                end
            end
            @(posedge clock); #1;
            checks++;
            if (pc !== t_pc[k]) begin errors++; $display("FAIL flow_pc instr %0d: got %0d expected %0d", k, pc, t_pc[k]); end
            checks++;
            if (acc !== t_acc[k]) begin errors++; $display("FAIL flow_acc instr %0d: got %h expected %h", k, acc, t_acc[k]); end
            checks++;
            if (instr_cnt !== 16'(5 + k)) begin errors++; $display("FAIL flow_cnt instr %0d: got %0d expected %0d", k, instr_cnt, 5 + k); end
        end
    endtask

    task automatic test_reset_mid_write();
        push_instr(3'd1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL midwr_sb: queue empty at cycle %0d", i); end
            else begin
                exp_v = sb.pop_front();
                if (strobes !== exp_v) begin errors++; $display("FAIL midwr cycle %0d: got %h expected %h", i, strobes, exp_v); end
            end
        end
        reset_pc = 5'd9;
        #1 n_reset = 1'b0;
        #1;
        checks++;
        if (strobes !== B_RNW) begin errors++; $display("FAIL midwr_drop: got %h expected %h", strobes, B_RNW); end
        checks++;
        if (instr_cnt !== 16'd0) begin errors++; $display("FAIL midwr_cnt: got %0d expected 0", instr_cnt); end
        @(posedge clock); #1;
        checks++;
        if (ram[28] !== 8'h11) begin errors++; $display("FAIL midwr_ram: got %h expected 11", ram[28]); end
        checks++;
        if (strobes !== B_RNW) begin errors++; $display("FAIL midwr_hold: got %h expected %h", strobes, B_RNW); end
    endtask

    task automatic test_halt();
        int n;
        @(negedge clock);
        n_reset = 1'b1;
        #1;
        checks++;
        if (strobes !== B_RNW) begin errors++; $display("FAIL halt_s_reset: got %h expected %h", strobes, B_RNW); end
        push_instr(3'd7, 1'b0);
`ifdef HALT_SEQ_EN
        for (int i = 0; i < 20; i++) sb.push_back(B_HALT | B_RNW);
        n = 24;
`else
        push_instr(3'd0, 1'b0);
        n = 10;
`endif
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL halt_sb: queue empty at cycle %0d", i); end
            else begin
                exp_v = sb.pop_front();
                if (strobes !== exp_v) begin errors++; $display("FAIL halt cycle %0d: got %h expected %h", i, strobes, exp_v); end
            end
        end
        @(posedge clock); #1;
`ifdef HALT_SEQ_EN
        checks++;
        if (instr_cnt !== 16'd1) begin errors++; $display("FAIL halt_cnt: got %0d expected 1", instr_cnt); end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", halted); end
`else
        checks++;
        if (instr_cnt !== 16'd2) begin errors++; $display("FAIL halt_nop_cnt: got %0d expected 2", instr_cnt); end
        checks++;
        if (acc !== 8'h03) begin errors++; $display("FAIL halt_nop_acc: got %h expected 03", acc); end
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL halt_nop_flag: got %b expected 0", halted); end
`endif
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_store();
        test_bne_jmp();
        test_reset_mid_write();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
